// File: rtl/cmplx_pkg.sv
// Shared sizing helpers for the pipelined complex multiplier.
package cmplx_pkg;

  // Full-precision width: signed product plus one bit for the conjugate and one for the add.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 2;
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up / truncate, arithmetic shift and saturate to OUT_W.
module round_sat
  import cmplx_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int SHIFT = 15,
  parameter int ROUND = 1,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    ovf
);

  localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ((IN_W + 1)'(1) <<< SH_M1) : '0;
  localparam logic signed [IN_W:0]    T_MAX = (IN_W + 1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0]    T_MIN = (IN_W + 1)'(sat_min(OUT_W));
  localparam logic signed [OUT_W-1:0] Y_MAX = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0] Y_MIN = OUT_W'(sat_min(OUT_W));

  logic signed [IN_W:0] t;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    t   = ($signed({x[IN_W-1], x}) + RND) >>> SHIFT;
    y   = t[OUT_W-1:0];
    ovf = 1'b0;
    if (t > T_MAX) begin
      y   = Y_MAX;
      ovf = 1'b1;
    end else if (t < T_MIN) begin
      y   = Y_MIN;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/cmplx_mult_pipe.sv
// Three-stage signed complex multiplier a*b (optionally conj(a)*b) with scaling,
// saturation, overflow flags and a valid/ready handshake with a global stall.
module cmplx_mult_pipe
  import cmplx_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int ROUND = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_conj,
  input  logic signed [A_W-1:0]   i_data_ra,
  input  logic signed [A_W-1:0]   i_data_ca,
  input  logic signed [B_W-1:0]   i_data_rb,
  input  logic signed [B_W-1:0]   i_data_cb,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [OUT_W-1:0] o_data_r,
  output logic signed [OUT_W-1:0] o_data_c,
  output logic                    o_ovf,
  input  logic                    i_clr_ovf,
  output logic                    o_ovf_sticky
);

  localparam int P = prod_w(A_W, B_W);

  logic en;
  logic v1, v2;

  logic signed [A_W-1:0] s1_ra;
  logic signed [A_W:0]   s1_ca;
  logic signed [B_W-1:0] s1_rb, s1_cb;
  logic signed [A_W:0]   ca_ext, ca_eff;

  logic signed [P-1:0] ra_x, ca_x, rb_x, cb_x;
  logic signed [P-1:0] pp_rr, pp_cc, pp_rc, pp_cr;
  logic signed [P-1:0] re_full, im_full;

  logic signed [OUT_W-1:0] re_y, im_y;
  logic                    re_ovf, im_ovf;

  // The output register being free (empty or draining) lets the whole pipe advance.
  assign en      = ~o_valid | o_ready;
  assign i_ready = en;

  // Extra bit keeps -(-2^(A_W-1)) exact when conjugating.
  assign ca_ext = (A_W + 1)'(i_data_ca);
  assign ca_eff = i_conj ? -ca_ext : ca_ext;

  assign ra_x = P'(s1_ra);
  assign ca_x = P'(s1_ca);
  assign rb_x = P'(s1_rb);
  assign cb_x = P'(s1_cb);

  assign re_full = pp_rr - pp_cc;
  assign im_full = pp_rc + pp_cr;

  round_sat #(.IN_W(P), .SHIFT(SHIFT), .ROUND(ROUND), .OUT_W(OUT_W)) u_rs_re (
    .x   (re_full),
    .y   (re_y),
    .ovf (re_ovf)
  );

  round_sat #(.IN_W(P), .SHIFT(SHIFT), .ROUND(ROUND), .OUT_W(OUT_W)) u_rs_im (
    .x   (im_full),
    .y   (im_y),
    .ovf (im_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      o_valid  <= 1'b0;
      s1_ra    <= '0;
      s1_ca    <= '0;
      s1_rb    <= '0;
      s1_cb    <= '0;
      pp_rr    <= '0;
      pp_cc    <= '0;
      pp_rc    <= '0;
      pp_cr    <= '0;
      o_data_r <= '0;
      o_data_c <= '0;
      o_ovf    <= 1'b0;
    end else if (en) begin
      v1      <= i_valid;
      v2      <= v1;
      o_valid <= v2;
      // Data registers only load behind a valid sample; bubbles leave them untouched.
      if (i_valid) begin
        s1_ra <= i_data_ra;
        s1_ca <= ca_eff;
        s1_rb <= i_data_rb;
        s1_cb <= i_data_cb;
      end
      if (v1) begin
        pp_rr <= ra_x * rb_x;
        pp_cc <= ca_x * cb_x;
        pp_rc <= ra_x * cb_x;
        pp_cr <= ca_x * rb_x;
      end
      if (v2) begin
        o_data_r <= re_y;
        o_data_c <= im_y;
        o_ovf    <= re_ovf | im_ovf;
      end
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ovf_sticky <= 1'b0;
    end else if (o_valid && o_ready && o_ovf) begin
      o_ovf_sticky <= 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Self-checking bench: directed cases plus a randomized backpressure stream against a math model.
module tb_cmplx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_conj, o_ready, i_clr_ovf;
  logic [15:0] i_data_ra, i_data_ca, i_data_rb, i_data_cb;
  logic        i_ready, o_valid, o_ovf, o_ovf_sticky;
  logic [15:0] o_data_r, o_data_c;
  logic        t_ready, t_valid, t_ovf, t_sticky;
  logic [15:0] t_data_r, t_data_c;

  always #5 clk = ~clk;

  cmplx_mult_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .ROUND(1)) u_dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_conj(i_conj),
    .i_data_ra(i_data_ra), .i_data_ca(i_data_ca), .i_data_rb(i_data_rb), .i_data_cb(i_data_cb),
    .o_valid(o_valid), .o_ready(o_ready), .o_data_r(o_data_r), .o_data_c(o_data_c),
    .o_ovf(o_ovf), .i_clr_ovf(i_clr_ovf), .o_ovf_sticky(o_ovf_sticky)
  );

  cmplx_mult_pipe #(.A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(t_ready), .i_conj(i_conj),
    .i_data_ra(i_data_ra), .i_data_ca(i_data_ca), .i_data_rb(i_data_rb), .i_data_cb(i_data_cb),
    .o_valid(t_valid), .o_ready(o_ready), .o_data_r(t_data_r), .o_data_c(t_data_c),
    .o_ovf(t_ovf), .i_clr_ovf(i_clr_ovf), .o_ovf_sticky(t_sticky)
  );

  typedef struct {
    logic [15:0] r, c;
    logic        ovf;
    logic [15:0] tr, tc;
    logic        tovf;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_out  = 0;
  bit          in_x, out_x;
  bit          hold_prev = 1'b0;
  logic [15:0] prev_r, prev_c;
  logic        prev_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scale a full-precision value by 2^-15 (floor), optionally rounding half up, then clamp.
  function automatic void scale(input longint x, input bit rnd, output logic [15:0] y, output logic o);
    longint t;
    t = (x + (rnd ? 64'sd16384 : 64'sd0)) >>> 15;
    o = 1'b0;
    if (t > 32767) begin
      t = 32767;
      o = 1'b1;
    end else if (t < -32768) begin
      t = -32768;
      o = 1'b1;
    end
    y = 16'(t);
  endfunction

  function automatic exp_t model(input logic [15:0] ra, ca, rb, cb, input logic conj);
    exp_t   e;
    longint sra, sca, srb, scb, re, im;
    logic   o1, o2, o3, o4;
    sra = longint'($signed(ra));
    sca = longint'($signed(ca));
    srb = longint'($signed(rb));
    scb = longint'($signed(cb));
    if (conj) sca = -sca;
    re = sra * srb - sca * scb;
    im = sra * scb + sca * srb;
    scale(re, 1'b1, e.r, o1);
    scale(im, 1'b1, e.c, o2);
    scale(re, 1'b0, e.tr, o3);
    scale(im, 1'b0, e.tc, o4);
    e.ovf  = o1 | o2;
    e.tovf = o3 | o4;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock cycle: drive after the falling edge, observe 1 time unit later, score transfers.
  task automatic step(input bit v, input bit conj, input logic [15:0] ra, ca, rb, cb,
                      input bit ordy, input bit clr);
    exp_t e;
    @(negedge clk);
    i_valid   = v;
    i_conj    = conj;
    i_data_ra = ra;
    i_data_ca = ca;
    i_data_rb = rb;
    i_data_cb = cb;
    o_ready   = ordy;
    i_clr_ovf = clr;
    #1;
    if (hold_prev) begin
      check("hold_valid", o_valid, 1'b1);
      check("hold_r", o_data_r, prev_r);
      check("hold_c", o_data_c, prev_c);
      check("hold_ovf", o_ovf, prev_ovf);
    end
    hold_prev = o_valid && !o_ready;
    prev_r    = o_data_r;
    prev_c    = o_data_c;
    prev_ovf  = o_ovf;
    in_x  = i_valid && i_ready;
    out_x = o_valid && o_ready;
    if (in_x) exp_q.push_back(model(ra, ca, rb, cb, conj));
    if (out_x) begin
      n_out++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_out observed=output expected=no_output");
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model_r", o_data_r, e.r);
        check("model_c", o_data_c, e.c);
        check("model_ovf", o_ovf, e.ovf);
        check("trunc_valid", t_valid, 1'b1);
        check("trunc_r", t_data_r, e.tr);
        check("trunc_c", t_data_c, e.tc);
        check("trunc_ovf", t_ovf, e.tovf);
      end
    end
  endtask

  // Send one sample into an idle pipe and check constants plus 3-cycle latency.
  task automatic directed(input string tag, input logic [15:0] ra, ca, rb, cb, input bit conj,
                          input logic [15:0] er, ec, input bit eovf, input logic [15:0] etr,
                          input bit clr_at_out);
    int lat;
    lat = -1;
    step(1'b1, conj, ra, ca, rb, cb, 1'b1, 1'b0);
    check({tag, "_accept"}, in_x, 1'b1);
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      step(1'b0, 1'($urandom), rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, clr_at_out && i == 3);
      if (out_x) begin
        lat = i;
        check({tag, "_r"}, o_data_r, er);
        check({tag, "_c"}, o_data_c, ec);
        check({tag, "_ovf"}, o_ovf, eovf);
        check({tag, "_trunc_r"}, t_data_r, etr);
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    i_valid = 0; i_conj = 0; o_ready = 1; i_clr_ovf = 0;
    i_data_ra = 0; i_data_ca = 0; i_data_rb = 0; i_data_cb = 0;
    rst = 1'b1;
    #1;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_data_r", o_data_r, 16'h0);
    check("rst_o_data_c", o_data_c, 16'h0);
    check("rst_o_ovf", o_ovf, 1'b0);
    check("rst_sticky", o_ovf_sticky, 1'b0);
    check("rst_i_ready", i_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_i_ready", i_ready, 1'b1);

    directed("basic", 16'h4000, 16'h0000, 16'h2000, 16'h2000, 1'b0, 16'h1000, 16'h1000, 1'b0, 16'h1000, 1'b0);
    directed("conj0", 16'h0000, 16'h4000, 16'h2000, 16'h0000, 1'b0, 16'h0000, 16'h1000, 1'b0, 16'h0000, 1'b0);
    directed("conj1", 16'h0000, 16'h4000, 16'h2000, 16'h0000, 1'b1, 16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0);
    directed("round_pos", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0);
    directed("round_neg", 16'h0001, 16'h0000, 16'hC000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    check("sticky_before_sat", o_ovf_sticky, 1'b0);

    directed("sat", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 1'b0);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("sticky_set", o_ovf_sticky, 1'b1);
    directed("sat_clr", 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("sticky_set_wins", o_ovf_sticky, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("sticky_cleared", o_ovf_sticky, 1'b0);

    sent  = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 600 && (sent < 20 || exp_q.size() > 0); cyc++) begin
      step(sent < 20 && $urandom_range(0, 3) != 0, 1'($urandom), rnd16(), rnd16(), rnd16(), rnd16(),
           1'($urandom_range(0, 1)), 1'b0);
      if (in_x) sent++;
    end
    check("stream_sent", 32'(sent), 32'd20);
    check("stream_received", 32'(n_out), 32'd20);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rnd16(), rnd16(), rnd16(), rnd16(), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_o_valid", o_valid, 1'b0);
    check("midrst_o_data_r", o_data_r, 16'h0);
    check("midrst_o_data_c", o_data_c, 16'h0);
    check("midrst_o_ovf", o_ovf, 1'b0);
    check("midrst_i_ready", i_ready, 1'b1);
    exp_q.delete();
    hold_prev = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    directed("after_rst", 16'h2000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 16'h1000, 16'h0000, 1'b0, 16'h1000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    check("after_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
